// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode/pipeline definitions for the hazard controller:
// RV32I major opcodes and the controller state encoding.
package hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Width of the dmem wait counter; covers WAIT_LIMIT up to 65535.
  localparam int unsigned WCNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_rs_use_decode.sv
// rs_use_decode: which source operands the instruction in ID actually reads.
// Purely combinational.
module rs_use_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_rs1_used,
  output logic       o_rs2_used
);

  // Decode operand usage from the major opcode.
  always_comb begin
    o_rs1_used = 1'b1;
    o_rs2_used = 1'b0;
    case (i_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
      end
      OPC_BRANCH, OPC_STORE, OPC_OP: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
      end
      default: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble control for the 3-stage core.
// Handles load-use bubbles, EX redirects (two-cycle front-end flush) and
// multi-cycle dmem accesses, with a sticky dmem wait timeout.
// Optional feature: define HAZARD_CTRL_PERF_EN to add perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_addr_id,
  input  logic [4:0] rs2_addr_id,
  input  logic [6:0] opcode_id,
  input  logic [4:0] rd_addr_ex,
  input  logic [6:0] opcode_ex,
  input  logic       ctrl_reg_we_ex,
  input  logic       redirect_ex,
  input  logic       dmem_req_ex,
  input  logic       dmem_ready,
  output logic       stall_pc,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       mem_timeout
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [DWIDTH-1:0] perf_stall_cycles,
  output logic [DWIDTH-1:0] perf_flush_cycles,
  output logic [DWIDTH-1:0] perf_bubbles
`endif
);

  localparam logic [WCNT_W-1:0] LIMIT_C = WCNT_W'(WAIT_LIMIT);

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic              r_flush_pend;
  logic              w_pend_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;

  logic w_rs1_used;
  logic w_rs2_used;
  logic w_luse;
  logic w_mwait;
  logic w_flush_owed;
  logic w_stall_all;
  logic w_luse_take;
  logic w_flush;
  logic w_bubble;

  rs_use_decode u_rs_use_decode (
    .i_opcode   (opcode_id),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used)
  );

  assign w_luse = (opcode_ex == OPC_LOAD) && ctrl_reg_we_ex && (rd_addr_ex != 5'd0) &&
                  ((w_rs1_used && (rs1_addr_id == rd_addr_ex)) ||
                   (w_rs2_used && (rs2_addr_id == rd_addr_ex)));
  assign w_mwait = dmem_req_ex && !dmem_ready;

  // A front-end flush cycle is owed in FLUSH, and on the exit cycle of a
  // MEM_WAIT that interrupted FLUSH (the wrong-path fetch is still held in
  // IF/ID and must be killed as the pipe starts moving again).
  always_comb begin
    w_flush_owed = 1'b0;
    case (r_state)
      ST_FLUSH:    w_flush_owed = 1'b1;
      ST_MEM_WAIT: w_flush_owed = r_flush_pend;
      default:     w_flush_owed = 1'b0;
    endcase
  end

  // Next-state and hazard resolution; priority mwait > redirect > owed flush > load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_flush_pend;
    w_stall_all = 1'b0;
    w_luse_take = 1'b0;
    w_flush     = 1'b0;
    w_bubble    = 1'b0;
    if (w_mwait) begin
      w_stall_all = 1'b1;
      w_state_nxt = ST_MEM_WAIT;
      if (r_state == ST_FLUSH) begin
        w_pend_nxt = 1'b1;
      end else begin
        w_pend_nxt = r_flush_pend;
      end
    end else begin
      w_pend_nxt = 1'b0;
      if (redirect_ex) begin
        w_flush     = 1'b1;
        w_bubble    = 1'b1;
        w_state_nxt = ST_FLUSH;
      end else if (w_flush_owed) begin
        w_flush     = 1'b1;
        w_state_nxt = ST_RUN;
      end else begin
        w_luse_take = w_luse;
        w_bubble    = w_luse;
        w_state_nxt = ST_RUN;
      end
    end
  end

  // While in reset the front end is held flushed and nothing stalls.
  assign stall_pc    = rst_n & (w_stall_all | w_luse_take);
  assign stall_id    = rst_n & (w_stall_all | w_luse_take);
  assign stall_ex    = rst_n & w_stall_all;
  assign bubble_ex   = rst_n & w_bubble;
  assign flush_id    = ~rst_n | w_flush;
  assign mem_timeout = r_mem_timeout;

  // State, pending-flush flag, saturating wait counter and sticky timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_flush_pend  <= 1'b0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_pend_nxt;
      if (w_mwait) begin
        if (r_wait_cnt != LIMIT_C) begin
          r_wait_cnt <= r_wait_cnt + {{(WCNT_W-1){1'b0}}, 1'b1};
        end
        if (r_wait_cnt >= (LIMIT_C - {{(WCNT_W-1){1'b0}}, 1'b1})) begin
          r_mem_timeout <= 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [DWIDTH-1:0] r_perf_stall;
  logic [DWIDTH-1:0] r_perf_flush;
  logic [DWIDTH-1:0] r_perf_bubble;

  // Wrapping event counters for stall cycles, flush cycles and load-use bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall  <= '0;
      r_perf_flush  <= '0;
      r_perf_bubble <= '0;
    end else begin
      r_perf_stall  <= r_perf_stall  + {{(DWIDTH-1){1'b0}}, stall_pc};
      r_perf_flush  <= r_perf_flush  + {{(DWIDTH-1){1'b0}}, flush_id};
      r_perf_bubble <= r_perf_bubble + {{(DWIDTH-1){1'b0}}, w_luse_take};
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_cycles = r_perf_flush;
  assign perf_bubbles      = r_perf_bubble;
`else
  // DWIDTH only sizes the perf counters, which are absent in this build.
  if (DWIDTH == 0) begin : g_no_perf
  end
`endif

endmodule
